// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a 4-digit multiplexed seven-segment display.
//   The scanned digit-select and segment lines are synchronised. Each dwell
//   is captured once it has been stable for STABLE_CYCLES samples, and the
//   segment pattern is decoded back to BCD. A complete in-order scan of
//   positions 0..3 is published as one frame with a single-cycle strobe.
//
// Ports
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   dig_in[3:0]  digit select, one-cold (0111=pos0 .. 1110=pos3, else blank)
//   smg_in[7:0]  segments, active-high {P,A,B,C,D,E,F,G}
//   digits[15:0] decoded frame, position 0 in [15:12]
//   dp[3:0]      decimal point per position, bit3 = position 0
//   seg_err[3:0] illegal-pattern flag per position, bit3 = position 0
//   frame_valid  one-cycle pulse when digits/dp/seg_err update
//   frame_err    one-cycle pulse on a scan-order violation
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dig_in,
  input  logic [7:0]  smg_in,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

  typedef enum logic {HUNT, COLLECT} state_t;

  // input synchroniser and history
  logic [3:0]  sync_dig_reg;
  logic [7:0]  sync_smg_reg;
  logic [3:0]  s_dig;
  logic [7:0]  s_smg;
  logic [11:0] prev_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic        changed;

  // capture
  logic        pos_legal;
  logic [1:0]  cap_pos;
  logic [3:0]  cap_digit;
  logic        cap_bad;
  logic        capture;

  // frame FSM
  state_t      state_reg, state_next;
  logic [1:0]  exp_reg, exp_next;
  logic [3:0]  shadow_wr;
  logic        shadow_clr;
  logic [3:0][5:0] shadow;   // per slot {err, dp, digit}

  logic [15:0] digits_reg, digits_next;
  logic [3:0]  dp_reg, dp_next;
  logic [3:0]  err_reg, err_next;
  logic        fv_reg, fv_next;
  logic        fe_reg, fe_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_dig_reg <= 4'hF;
      sync_smg_reg <= 8'hFF;
      s_dig        <= 4'hF;
      s_smg        <= 8'hFF;
      prev_reg     <= 12'hFFF;
      cnt_reg      <= 8'd0;
    end else begin
      sync_dig_reg <= dig_in;
      sync_smg_reg <= smg_in;
      s_dig        <= sync_dig_reg;
      s_smg        <= sync_smg_reg;
      prev_reg     <= {s_dig, s_smg};
      cnt_reg      <= cnt_next;
    end
  end

  assign changed = ({s_dig, s_smg} != prev_reg);

  always_comb begin
    cnt_next = cnt_reg;
    if (changed)
      cnt_next = 8'd0;
    else if (cnt_reg < STABLE_L)
      cnt_next = cnt_reg + 8'd1;
  end

  always_comb begin
    pos_legal = 1'b1;
    cap_pos   = 2'd0;
    case (s_dig)
      4'b0111: cap_pos = 2'd0;
      4'b1011: cap_pos = 2'd1;
      4'b1101: cap_pos = 2'd2;
      4'b1110: cap_pos = 2'd3;
      default: pos_legal = 1'b0;
    endcase
  end

  always_comb begin
    cap_bad   = 1'b0;
    cap_digit = 4'hF;
    case (s_smg[6:0])
      7'h7E: cap_digit = 4'd0;
      7'h30: cap_digit = 4'd1;
      7'h6D: cap_digit = 4'd2;
      7'h79: cap_digit = 4'd3;
      7'h33: cap_digit = 4'd4;
      7'h5B: cap_digit = 4'd5;
      7'h5F: cap_digit = 4'd6;
      7'h70: cap_digit = 4'd7;
      7'h7F: cap_digit = 4'd8;
      7'h7B: cap_digit = 4'd9;
      default: cap_bad = 1'b1;
    endcase
  end

  // Fires only on the STABLE-1 -> STABLE step, so a held dwell captures once.
  assign capture = !changed && (cnt_reg == STABLE_L - 8'd1) && pos_legal;

  // Shadow slots; a write wins over a clear so an out-of-order position 0
  // can restart the frame in the same cycle the old slots are discarded.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [5:0] slot_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          slot_reg <= 6'd0;
        else if (shadow_wr[gi])
          slot_reg <= {cap_bad, s_smg[7], cap_digit};
        else if (shadow_clr)
          slot_reg <= 6'd0;
      end
      assign shadow[gi] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= HUNT;
      exp_reg    <= 2'd0;
      digits_reg <= 16'h0000;
      dp_reg     <= 4'h0;
      err_reg    <= 4'h0;
      fv_reg     <= 1'b0;
      fe_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      exp_reg    <= exp_next;
      digits_reg <= digits_next;
      dp_reg     <= dp_next;
      err_reg    <= err_next;
      fv_reg     <= fv_next;
      fe_reg     <= fe_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    exp_next    = exp_reg;
    shadow_wr   = 4'b0000;
    shadow_clr  = 1'b0;
    digits_next = digits_reg;
    dp_next     = dp_reg;
    err_next    = err_reg;
    fv_next     = 1'b0;
    fe_next     = 1'b0;
    if (capture) begin
      case (state_reg)
        HUNT: begin
          if (cap_pos == 2'd0) begin
            shadow_wr[0] = 1'b1;
            state_next   = COLLECT;
            exp_next     = 2'd1;
          end
        end
        COLLECT: begin
          if (cap_pos == exp_reg) begin
            if (cap_pos == 2'd3) begin
              // last position goes straight to the outputs with slots 0..2
              digits_next = {shadow[0][3:0], shadow[1][3:0], shadow[2][3:0], cap_digit};
              dp_next     = {shadow[0][4], shadow[1][4], shadow[2][4], s_smg[7]};
              err_next    = {shadow[0][5], shadow[1][5], shadow[2][5], cap_bad};
              fv_next     = 1'b1;
              shadow_clr  = 1'b1;
              state_next  = HUNT;
            end else begin
              shadow_wr[cap_pos] = 1'b1;
              exp_next           = exp_reg + 2'd1;
            end
          end else begin
            fe_next    = 1'b1;
            shadow_clr = 1'b1;
            if (cap_pos == 2'd0) begin
              shadow_wr[0] = 1'b1;
              exp_next     = 2'd1;
            end else begin
              state_next = HUNT;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  assign digits      = digits_reg;
  assign dp          = dp_reg;
  assign seg_err     = err_reg;
  assign frame_valid = fv_reg;
  assign frame_err   = fe_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  localparam int STABLE = 4;
  localparam int EV_NONE  = 0;
  localparam int EV_VALID = 1;   // {frame_err, frame_valid} = 01
  localparam int EV_ERR   = 2;   // {frame_err, frame_valid} = 10

  logic        clk;
  logic        rst_n;
  logic [3:0]  dig_in;
  logic [7:0]  smg_in;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        frame_err;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dig_in(dig_in),
    .smg_in(smg_in),
    .digits(digits),
    .dp(dp),
    .seg_err(seg_err),
    .frame_valid(frame_valid),
    .frame_err(frame_err)
  );

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [3:0] pos_code [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every strobe is matched against the next scoreboard entry.
  always @(negedge clk) begin
    if (frame_valid || frame_err) begin
      $display("event cyc=%0d valid=%0b err=%0b digits=%h dp=%b seg_err=%b",
               cyc, frame_valid, frame_err, digits, dp, seg_err);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got valid=%0b err=%0b, expected none", frame_valid, frame_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_kind", {30'd0, frame_err, frame_valid}, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("digits", {16'd0, digits}, {16'd0, e.d});
        check("dp", {28'd0, dp}, {28'd0, e.p});
        check("seg_err", {28'd0, seg_err}, {28'd0, e.e});
      end
    end
  end

  // Drive one dwell of len cycles; if ev is set, that dwell's capture
  // produces a strobe 3+STABLE cycles after the pins change.
  task automatic dwell(input logic [3:0] d, input logic [7:0] s, input int len,
                       input int ev, input logic [15:0] ed, input logic [3:0] ep,
                       input logic [3:0] ee);
    exp_t e;
    dig_in = d;
    smg_in = s;
    if (ev != EV_NONE) begin
      e.kind = ev; e.cyc = cyc + 3 + STABLE; e.d = ed; e.p = ep; e.e = ee;
      sb.push_back(e);
    end
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic blank();
    dwell(4'hF, 8'h00, 2, EV_NONE, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic digit(input int pos, input logic [7:0] s, input int ev,
                       input logic [15:0] ed, input logic [3:0] ep, input logic [3:0] ee);
    dwell(pos_code[pos], s, 10, ev, ed, ep, ee);
    blank();
  endtask

  task automatic plain(input int pos, input logic [7:0] s);
    digit(pos, s, EV_NONE, 16'h0, 4'h0, 4'h0);
  endtask

  task automatic check_outputs(input string tag, input logic [15:0] ed,
                               input logic [3:0] ep, input logic [3:0] ee);
    check({tag, "_digits"}, {16'd0, digits}, {16'd0, ed});
    check({tag, "_dp"}, {28'd0, dp}, {28'd0, ep});
    check({tag, "_seg_err"}, {28'd0, seg_err}, {28'd0, ee});
  endtask

  initial begin
    rst_n  = 1'b0;
    dig_in = 4'hF;
    smg_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", 16'h0000, 4'h0, 4'h0);
    check("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    blank();

    // clean scan 1,2,3,4
    plain(0, 8'h30); plain(1, 8'h6D); plain(2, 8'h79);
    digit(3, 8'h33, EV_VALID, 16'h1234, 4'b0000, 4'b0000);

    // illegal pattern at position 2, decimal point at position 1
    plain(0, 8'h30); plain(1, 8'hED); plain(2, 8'h00);
    digit(3, 8'h33, EV_VALID, 16'h12F4, 4'b0100, 4'b0010);

    // order 0,1,3 -> order error, outputs hold; then a clean scan 0,1,2,3
    plain(0, 8'h5B); plain(1, 8'h5F);
    digit(3, 8'h7F, EV_ERR, 16'h12F4, 4'b0100, 4'b0010);
    plain(0, 8'h7E); plain(1, 8'h30); plain(2, 8'h6D);
    digit(3, 8'h79, EV_VALID, 16'h0123, 4'b0000, 4'b0000);

    // position 1 dwell too short; position 2 then breaks order, back to HUNT
    plain(0, 8'h33);
    dwell(pos_code[1], 8'h5B, 4, EV_NONE, 16'h0, 4'h0, 4'h0);
    blank();
    digit(2, 8'h7B, EV_ERR, 16'h0123, 4'b0000, 4'b0000);
    plain(3, 8'h70);   // ignored in HUNT
    plain(0, 8'h5B); plain(1, 8'h5F); plain(2, 8'h70);
    digit(3, 8'h7F, EV_VALID, 16'h5678, 4'b0000, 4'b0000);

    // one-cycle glitch early in the position 2 dwell
    plain(0, 8'h7B); plain(1, 8'h7E);
    dwell(pos_code[2], 8'h5B, 2, EV_NONE, 16'h0, 4'h0, 4'h0);
    dwell(pos_code[2], 8'h7F, 1, EV_NONE, 16'h0, 4'h0, 4'h0);
    dwell(pos_code[2], 8'h5B, 10, EV_NONE, 16'h0, 4'h0, 4'h0);
    blank();
    digit(3, 8'h5F, EV_VALID, 16'h9056, 4'b0000, 4'b0000);

    // reset just after the position 2 capture
    plain(0, 8'h30); plain(1, 8'h30);
    dig_in = pos_code[2];
    smg_in = 8'h30;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("midreset", 16'h0000, 4'h0, 4'h0);
    check("midreset_frame_valid", {31'd0, frame_valid}, 32'd0);
    @(posedge clk); #1;
    blank();
    plain(3, 8'h33);
    check_outputs("after_reset", 16'h0000, 4'h0, 4'h0);
    plain(0, 8'h70); plain(1, 8'h7F); plain(2, 8'h30);
    digit(3, 8'h30, EV_VALID, 16'h7811, 4'b0000, 4'b0000);

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pending_strobes", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
